// File: rtl/hilo_div_unit.sv
// HI/LO register file with a 32-cycle restoring divider (signed/unsigned) and mthi/mtlo/load_mul writes.
// Define HILO_FWD_EN to forward mthi/mtlo/load_mul write data combinationally onto hi/lo.
module hilo_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_LMUL = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, FIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dbz_q, dbz_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        idle_cmd;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;

  assign idle_cmd = (state_q == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: cnt 0 is the magnitude-prep cycle, cnt 1..32 are the iterations
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (op == OP_DIV || op == OP_DIVU)) state_d = DIV;
      DIV:     if (cnt_q == 6'd32) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step on the magnitudes
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_nx = diff[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    sgn_d  = sgn_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dbz_d  = dbz_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_DIV, OP_DIVU: begin
              a_d   = a;
              b_d   = b;
              sgn_d = (op == OP_DIV);
              cnt_d = 6'd0;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_LMUL: begin
              hi_d = mul_hi;
              lo_d = mul_lo;
            end
            default: ;
          endcase
        end
      end
      DIV: begin
        if (cnt_q == 6'd0) begin
          quo_d  = (sgn_q && a_q[31]) ? -a_q : a_q;
          dvs_d  = (sgn_q && b_q[31]) ? -b_q : b_q;
          rem_d  = 32'd0;
          negq_d = sgn_q && (a_q[31] ^ b_q[31]);
          negr_d = sgn_q && a_q[31];
          cnt_d  = 6'd1;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd32) begin
            cnt_d = 6'd0;
            dbz_d = (dvs_q == 32'd0);
            if (dvs_q == 32'd0) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = negr_q ? -rem_nx : rem_nx;
              lo_d = negq_q ? -quo_nx : quo_nx;
            end
          end
        end
      end
      FIN:     dbz_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 6'd0;
      sgn_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dbz_q  <= 1'b0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      sgn_q  <= sgn_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dbz_q  <= dbz_d;
      a_q    <= a_d;
      b_q    <= b_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Output logic; in IDLE hi_d/lo_d differ from the registers only for mthi/mtlo/load_mul
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIN);
    dbz  = (state_q == FIN) && dbz_q;
`ifdef HILO_FWD_EN
    hi = idle_cmd ? hi_d : hi_q;
    lo = idle_cmd ? lo_d : lo_q;
`else
    hi = hi_q;
    lo = lo_q;
`endif
  end

endmodule
